rgb_pwm_fader: RTL

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

---
 rtl/rgb_pwm_fader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: fades one RGB channel at a time up and down with a PWM,
// cycling red -> green -> blue. The fade starts only after the PLL lock flag
// has been stable for LOCK_DELAY cycles. Losing lock returns everything to idle.
module rgb_pwm_fader #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP_DIV   = 65536,
    parameter int unsigned LOCK_DELAY = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic [2:0] rgb_leds,
    output logic [1:0] color_idx,
    output logic       running
);

    localparam int unsigned SW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
    localparam int unsigned PW = $clog2(STEP_DIV);

    localparam logic [PWM_BITS-1:0] DUTY_MAX      = '1;
    localparam logic [PWM_BITS-1:0] DUTY_NEAR_TOP = DUTY_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE      = PWM_BITS'(1);
    localparam logic [SW-1:0]       SETTLE_LAST   = SW'(LOCK_DELAY - 1);
    localparam logic [PW-1:0]       PRESC_LAST    = PW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StUp,
        StDown
    } state_t;

    state_t              state_q, state_d;
    logic                sync_meta;
    logic                lock_s;
    logic [SW-1:0]       settle_q, settle_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [1:0]          color_q, color_d;
    logic [2:0]          leds_q, leds_d;
    logic                running_q;

    logic active;
    logic step;
    logic pwm_on;

    assign active = (state_q == StUp) || (state_q == StDown);
    assign step   = active && (presc_q == PRESC_LAST);
    assign pwm_on = active && (pwm_cnt_q < duty_act_q);

    // Two-flop synchronizer for the asynchronous PLL lock flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            lock_s    <= sync_meta;
        end
    end

    // Next-state logic for the FSM and the fade/PWM datapath.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        presc_d    = presc_q;
        duty_d     = duty_q;
        duty_act_d = duty_act_q;
        pwm_cnt_d  = pwm_cnt_q;
        color_d    = color_q;

        if (!lock_s) begin
            // Lock loss wins over everything: drop back to a clean idle.
            state_d    = StIdle;
            settle_d   = '0;
            presc_d    = '0;
            duty_d     = '0;
            duty_act_d = '0;
            pwm_cnt_d  = '0;
            color_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StSettle;
                    settle_d  = '0;
                    presc_d   = '0;
                    pwm_cnt_d = '0;
                end
                StSettle: begin
                    presc_d   = '0;
                    pwm_cnt_d = '0;
                    if (settle_q == SETTLE_LAST) begin
                        state_d = StUp;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                StUp, StDown: begin
                    pwm_cnt_d = pwm_cnt_q + 1'b1;
                    presc_d   = step ? '0 : presc_q + 1'b1;
                    // Shadow load at the period boundary uses the pre-step duty.
                    if (pwm_cnt_q == DUTY_MAX) begin
                        duty_act_d = duty_q;
                    end
                    if (step) begin
                        if (state_q == StUp) begin
                            if (duty_q != DUTY_MAX) begin
                                duty_d = duty_q + 1'b1;
                            end
                            if (duty_q == DUTY_NEAR_TOP || duty_q == DUTY_MAX) begin
                                state_d = StDown;
                            end
                        end else begin
                            if (duty_q != '0) begin
                                duty_d = duty_q - 1'b1;
                            end
                            if (duty_q == DUTY_ONE || duty_q == '0) begin
                                state_d = StUp;
                                color_d = (color_q == 2'd2) ? 2'd0 : color_q + 2'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Output decode: pull the selected channel low while the PWM is on.
    always_comb begin
        leds_d = 3'b111;
        if (pwm_on) begin
            case (color_q)
                2'd0:    leds_d[0] = 1'b0;
                2'd1:    leds_d[1] = 1'b0;
                default: leds_d[2] = 1'b0;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            settle_q   <= '0;
            presc_q    <= '0;
            duty_q     <= '0;
            duty_act_q <= '0;
            pwm_cnt_q  <= '0;
            color_q    <= '0;
            leds_q     <= 3'b111;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            presc_q    <= presc_d;
            duty_q     <= duty_d;
            duty_act_q <= duty_act_d;
            pwm_cnt_q  <= pwm_cnt_d;
            color_q    <= color_d;
            leds_q     <= leds_d;
            running_q  <= active;
        end
    end

    assign rgb_leds  = leds_q;
    assign color_idx = color_q;
    assign running   = running_q;

endmodule
